dram_pcie_read_streamer: RTL and testbench
==========================================

Name: dram_pcie_read_streamer

Overview:
- Read-back stage that sits between a job-command source (write-side FSM or softreg control) and the DRAM interleaver input port.
- Accepts a read job (base address, line count, PCIe slot/pad), issues one 64-byte DRAM read per line, and caps in-flight reads with a credit counter.
- Pairs each returning response with queued job context and emits PCIEPacket beats, setting last on the final line of each job.

Parameters:
- MAX_OUTSTANDING, 32, max DRAM reads granted but not yet retired to PCIe.
- LOG_CTX_DEPTH, 6, log2 depth of context FIFO; 2^LOG_CTX_DEPTH >= MAX_OUTSTANDING is required (elaboration error otherwise).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  read-job command valid
- cmd_ready  out  1  command accepted when valid&&ready
- cmd_addr  in  64  byte base address, 64B aligned (low 6 bits ignored)
- cmd_lines  in  32  number of 64B lines to read
- cmd_slot  in  16  PCIe slot for all beats of job
- cmd_pad  in  4  PCIe pad for all beats of job
- mem_req_out  out  $bits(MemReq)  read request to interleaver; isWrite=0, data=0
- mem_req_grant_in  in  1  request consumed this cycle
- mem_resp_in  in  $bits(MemResp)  read response
- mem_resp_grant_out  out  1  response consumed this cycle
- pcie_packet_out  out  $bits(PCIEPacket)  outgoing beat
- pcie_grant_in  in  1  beat consumed this cycle
- busy  out  1  job issuing or reads outstanding
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count
- err_orphan  out  1  sticky: response arrived with context FIFO empty

Behaviour:
- Reset, and the first cycle after: state IDLE, outstanding=0, context FIFO empty, err_orphan=0, mem_req_out.valid=0, pcie_packet_out.valid=0, mem_resp_grant_out=0, busy=0; cmd_ready=1 from the first cycle after reset.
- FSM IDLE: cmd_ready=1. On accept, latch addr (low 6 bits cleared), lines, slot, pad.
  - cmd_lines==0: command consumed, no reads, no packets, stay IDLE.
  - cmd_lines>0: go to ISSUE.
- FSM ISSUE: cmd_ready=0.
  - Drive mem_req_out.valid=1 with addr=cur_addr only when outstanding<MAX_OUTSTANDING and context FIFO is not full; otherwise valid=0.
  - On grant: cur_addr+=64 (wraps mod 2^64); remaining-=1; push context {last: remaining==1, slot, pad}; outstanding+=1.
  - Grant on the final line: next state IDLE. A new command may be accepted the following cycle while prior reads remain outstanding.
- Request path latency: the request is visible in the cycle after ISSUE entry; back-to-back grants give one read per cycle.
- Response path is combinational, with the same cycle handshake as the existing loopback role:
  - pcie_packet_out.valid = mem_resp_in.valid && !ctx_empty; data=mem_resp_in.data; slot/pad/last taken from the context FIFO head.
  - When pcie_grant_in and valid: assert mem_resp_grant_out, pop context, outstanding-=1.
- Simultaneous issue grant and response retire in one cycle: outstanding unchanged; FIFO push and pop both occur.
- Responses return in request order (interleaver guarantee); no reordering is performed.
- mem_resp_in.valid with context FIFO empty: no grant, no packet, err_orphan set until rst.
- pcie_grant_in low: response held; mem_resp_grant_out=0. Issuing continues until credits are exhausted.
- busy = (state==ISSUE) || (outstanding!=0).
- Reset mid-job: all state and FIFO contents discarded immediately. Responses still in flight after reset are the system's responsibility.

Decomposition:
- Shared package (alongside ShellTypes): typedef ReadJobCmd {addr, lines, slot, pad}; typedef ReadCtx {last, slot[15:0], pad[3:0]}; constant LINE_BYTES=64.
- MemReq, MemResp and PCIEPacket come from ShellTypes.
- Context queue is the existing FIFO module (WIDTH=$bits(ReadCtx), LOG_DEPTH=LOG_CTX_DEPTH). No other sub-module; FSM and credit counter are inline.

Test Plan:
- Single job, addr=0x1000, lines=4, slot=7, pcie_grant_in=1, 3-cycle memory latency -> reads at 0x1000/0x1040/0x1080/0x10C0; 4 beats slot=7, last only on 4th; outstanding returns to 0; busy drops.
- lines=0 command -> accepted in 1 cycle, no mem_req_out.valid, no packets, state stays IDLE.
- MAX_OUTSTANDING=4, lines=10, memory never responds -> exactly 4 grants then valid=0; outstanding=4. Release responses -> remaining 6 issued; 10 beats total.
- pcie_grant_in low for 20 cycles mid-job -> mem_resp_grant_out=0 throughout, no data loss, beat order preserved after release.
- Back-to-back jobs A (slot 1, 3 lines) and B (slot 2, 2 lines) -> B accepted while A outstanding; output slots 1,1,1(last),2,2(last).
- Inject mem_resp_in.valid with nothing outstanding -> err_orphan=1 sticky, no packet. Assert rst mid-job -> outstanding=0, busy=0, err_orphan=0 the next cycle.

Source files
------------

// File: rtl/dram_pcie_read_streamer_pkg.sv
// Types and constants for the DRAM -> PCIe read streamer.
//   ReadJobCmd : one read job (byte base address, line count, PCIe slot/pad)
//   ReadCtx    : per-read context queued until the matching response returns
//   state_t    : job FSM states
package dram_pcie_read_streamer_pkg;

  localparam int LINE_BYTES = 64;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] lines;
    logic [15:0] slot;
    logic [3:0]  pad;
  } ReadJobCmd;

  typedef struct packed {
    logic        last;
    logic [15:0] slot;
    logic [3:0]  pad;
  } ReadCtx;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // Drop the byte offset inside a 64-byte line.
  function automatic logic [63:0] line_align(input logic [63:0] a);
    return {a[63:6], 6'b0};
  endfunction

endpackage

// File: rtl/shell_types.sv
// Shell-wide transport types shared by the memory and PCIe sides.
//   MemReq     : request into the DRAM interleaver (valid, isWrite, addr, data)
//   MemResp    : response out of the DRAM interleaver (valid, data)
//   PCIEPacket : outgoing PCIe beat (valid, data, slot, pad, last)
package ShellTypes;

  localparam int MEM_DATA_W = 512;

  typedef struct packed {
    logic                  valid;
    logic                  isWrite;
    logic [63:0]           addr;
    logic [MEM_DATA_W-1:0] data;
  } MemReq;

  typedef struct packed {
    logic                  valid;
    logic [MEM_DATA_W-1:0] data;
  } MemResp;

  typedef struct packed {
    logic                  valid;
    logic [MEM_DATA_W-1:0] data;
    logic [15:0]           slot;
    logic [3:0]            pad;
    logic                  last;
  } PCIEPacket;

endpackage

// File: rtl/dram_pcie_read_streamer_fifo.sv
// Synchronous FIFO with a combinational head read, so the consumer can pair
// the head entry with an incoming beat in the same cycle.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (clears pointers)
//   push, push_data : enqueue (ignored when full)
//   pop             : dequeue (ignored when empty)
//   head            : oldest entry, valid while !empty
//   empty, full     : occupancy flags
module dram_pcie_read_streamer_fifo #(
  parameter int WIDTH     = 21,
  parameter int LOG_DEPTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_reg;
  logic [LOG_DEPTH-1:0] rd_ptr_reg;
  logic [LOG_DEPTH:0]   count_reg;

  logic do_push;
  logic do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (LOG_DEPTH+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/dram_pcie_read_streamer.sv
// Read-back stage between a job-command source and the DRAM interleaver.
// A job (base address, line count, slot, pad) becomes one 64-byte read per
// line; in-flight reads are capped by a credit counter. Each response is
// paired with the queued context of its read and forwarded as a PCIe beat,
// with last set on the final line of the job.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   cmd_*               : read-job command handshake and fields
//   mem_req_out         : read request (isWrite=0, data=0)
//   mem_req_grant_in    : request consumed this cycle
//   mem_resp_in         : read response, in request order
//   mem_resp_grant_out  : response consumed this cycle
//   pcie_packet_out     : outgoing beat
//   pcie_grant_in       : beat consumed this cycle
//   busy                : job issuing or reads outstanding
//   outstanding         : reads granted but not yet retired
//   err_orphan          : sticky, a response arrived with no context queued
module dram_pcie_read_streamer
  import ShellTypes::*;
  import dram_pcie_read_streamer_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 32,
  parameter int LOG_CTX_DEPTH   = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [63:0]                          cmd_addr,
  input  logic [31:0]                          cmd_lines,
  input  logic [15:0]                          cmd_slot,
  input  logic [3:0]                           cmd_pad,
  output MemReq                                mem_req_out,
  input  logic                                 mem_req_grant_in,
  input  MemResp                               mem_resp_in,
  output logic                                 mem_resp_grant_out,
  output PCIEPacket                            pcie_packet_out,
  input  logic                                 pcie_grant_in,
  output logic                                 busy,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 err_orphan
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  // Every credit must have a context slot behind it.
  generate
    if ((2 ** LOG_CTX_DEPTH) < MAX_OUTSTANDING) begin : g_ctx_depth_check
      $error("context FIFO depth 2**LOG_CTX_DEPTH must be >= MAX_OUTSTANDING");
    end
  endgenerate

  state_t      state_reg;
  logic [63:0] cur_addr_reg;
  logic [31:0] remaining_reg;
  logic [15:0] slot_reg;
  logic [3:0]  pad_reg;
  logic [OW-1:0] outstanding_reg;
  logic        err_orphan_reg;

  ReadJobCmd cmd_job;
  ReadCtx    ctx_push_data;
  ReadCtx    ctx_head;
  logic      ctx_empty;
  logic      ctx_full;

  logic credit_ok;
  logic req_valid;
  logic req_fire;
  logic pkt_valid;
  logic retire;

  assign cmd_job = '{addr: line_align(cmd_addr), lines: cmd_lines,
                     slot: cmd_slot, pad: cmd_pad};

  assign credit_ok = (outstanding_reg < OW'(MAX_OUTSTANDING));
  assign req_valid = !rst && (state_reg == ST_ISSUE) && credit_ok && !ctx_full;
  assign req_fire  = req_valid && mem_req_grant_in;

  // Response path is combinational: a beat exists only when there is
  // context to pair it with.
  assign pkt_valid = !rst && mem_resp_in.valid && !ctx_empty;
  assign retire    = pkt_valid && pcie_grant_in;

  assign ctx_push_data = '{last: (remaining_reg == 32'd1), slot: slot_reg, pad: pad_reg};

  dram_pcie_read_streamer_fifo #(
    .WIDTH     ($bits(ReadCtx)),
    .LOG_DEPTH (LOG_CTX_DEPTH)
  ) u_ctx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (ctx_push_data),
    .pop       (retire),
    .head      (ctx_head),
    .empty     (ctx_empty),
    .full      (ctx_full)
  );

  assign cmd_ready = !rst && (state_reg == ST_IDLE);

  assign mem_req_out = '{valid: req_valid, isWrite: 1'b0,
                         addr: cur_addr_reg, data: '0};

  assign pcie_packet_out = '{valid: pkt_valid, data: mem_resp_in.data,
                             slot: ctx_head.slot, pad: ctx_head.pad,
                             last: ctx_head.last};

  assign mem_resp_grant_out = retire;
  assign busy               = (state_reg == ST_ISSUE) || (outstanding_reg != '0);
  assign outstanding        = outstanding_reg;
  assign err_orphan         = err_orphan_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      cur_addr_reg    <= '0;
      remaining_reg   <= '0;
      slot_reg        <= '0;
      pad_reg         <= '0;
      outstanding_reg <= '0;
      err_orphan_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            cur_addr_reg  <= cmd_job.addr;
            remaining_reg <= cmd_job.lines;
            slot_reg      <= cmd_job.slot;
            pad_reg       <= cmd_job.pad;
            // A zero-line job is consumed without issuing anything.
            if (cmd_job.lines != 32'd0) state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (req_fire) begin
            cur_addr_reg  <= cur_addr_reg + 64'(LINE_BYTES);
            remaining_reg <= remaining_reg - 32'd1;
            if (remaining_reg == 32'd1) state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      unique case ({req_fire, retire})
        2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
        2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
        default: outstanding_reg <= outstanding_reg;
      endcase

      if (mem_resp_in.valid && ctx_empty) err_orphan_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_pcie_read_streamer.sv
// Self-checking bench for dram_pcie_read_streamer. A queue-based model of
// jobs, in-flight reads and a fixed-latency in-order memory is checked
// against the DUT every cycle; directed scenarios add literal expectations.
module tb_dram_pcie_read_streamer;
  import ShellTypes::*;

  localparam int MAXO = 4;
  localparam int LOGD = 3;
  localparam int OW   = $clog2(MAXO + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [63:0] cmd_addr  = '0;
  logic [31:0] cmd_lines = '0;
  logic [15:0] cmd_slot  = '0;
  logic [3:0]  cmd_pad   = '0;
  MemReq       mem_req_out;
  logic        mem_req_grant_in = 1'b0;
  MemResp      mem_resp_in = '0;
  logic        mem_resp_grant_out;
  PCIEPacket   pcie_packet_out;
  logic        pcie_grant_in = 1'b0;
  logic        busy;
  logic [OW-1:0] outstanding;
  logic        err_orphan;

  dram_pcie_read_streamer #(.MAX_OUTSTANDING(MAXO), .LOG_CTX_DEPTH(LOGD)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_lines(cmd_lines), .cmd_slot(cmd_slot), .cmd_pad(cmd_pad),
    .mem_req_out(mem_req_out), .mem_req_grant_in(mem_req_grant_in),
    .mem_resp_in(mem_resp_in), .mem_resp_grant_out(mem_resp_grant_out),
    .pcie_packet_out(pcie_packet_out), .pcie_grant_in(pcie_grant_in),
    .busy(busy), .outstanding(outstanding), .err_orphan(err_orphan)
  );

  typedef struct {
    logic [63:0] addr;
    logic [15:0] slot;
    logic [3:0]  pad;
    logic        last;
  } beat_t;

  typedef struct {
    logic [63:0] addr;
    int          ready;
  } rd_t;

  beat_t todo_q[$];    // lines of accepted jobs not yet granted
  beat_t ctx_q[$];     // granted reads not yet retired
  rd_t   memq[$];      // reads held by the memory model
  bit    m_err = 1'b0;

  logic [63:0] req_log[$];
  beat_t       beat_log[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int mem_lat = 3;
  bit mem_hold = 1'b0;
  bit pcie_hold = 1'b0;
  bit inject_orphan = 1'b0;
  bit rand_mode = 1'b0;

  function automatic logic [511:0] line_data(input logic [63:0] a);
    logic [63:0] w;
    w = a ^ 64'h5A5A_0000_C3C3_0000;
    return {8{w}};
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic bound_fail(input string name);
    checks++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory and sink driver: in-order responses after mem_lat cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mem_resp_in.valid = 1'b0;
      if (inject_orphan) begin
        mem_resp_in.valid = 1'b1;
        mem_resp_in.data  = {16{$urandom()}};
      end else if (!mem_hold && memq.size() > 0) begin
        if (cyc >= memq[0].ready) begin
          mem_resp_in.valid = 1'b1;
          mem_resp_in.data  = line_data(memq[0].addr);
        end
      end
      mem_req_grant_in = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      pcie_grant_in    = pcie_hold ? 1'b0 :
                         (rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Per-cycle comparison against the model, then model update for the
  // handshakes that complete at the next rising edge.
  always @(negedge clk) begin : cmp
    bit    exp_rv;
    bit    exp_pv;
    beat_t b;
    rd_t   r;
    if (rst) begin
      todo_q.delete();
      ctx_q.delete();
      memq.delete();
      m_err = 1'b0;
    end else begin
      exp_rv = (todo_q.size() > 0) && (ctx_q.size() < MAXO);
      chk("cmd_ready", cmd_ready, todo_q.size() == 0);
      chk("req_valid", mem_req_out.valid, exp_rv);
      if (exp_rv) begin
        chk("req_addr", mem_req_out.addr, todo_q[0].addr);
        chk("req_is_write", mem_req_out.isWrite, 1'b0);
        chk("req_data", mem_req_out.data, '0);
      end
      chk("busy", busy, (todo_q.size() > 0) || (ctx_q.size() > 0));
      chk("outstanding", outstanding, ctx_q.size());
      chk("err_orphan", err_orphan, m_err);
      exp_pv = mem_resp_in.valid && (ctx_q.size() > 0);
      chk("pkt_valid", pcie_packet_out.valid, exp_pv);
      if (exp_pv) begin
        chk("pkt_data", pcie_packet_out.data, line_data(ctx_q[0].addr));
        chk("pkt_slot", pcie_packet_out.slot, ctx_q[0].slot);
        chk("pkt_pad", pcie_packet_out.pad, ctx_q[0].pad);
        chk("pkt_last", pcie_packet_out.last, ctx_q[0].last);
      end
      chk("resp_grant", mem_resp_grant_out, exp_pv && pcie_grant_in);

      if (mem_resp_in.valid && ctx_q.size() == 0) m_err = 1'b1;
      if (exp_pv && pcie_grant_in) begin
        b = ctx_q.pop_front();
        beat_log.push_back(b);
        $display("beat %0d: addr=%h slot=%0d pad=%0d last=%0b",
                 beat_log.size(), b.addr, b.slot, b.pad, b.last);
        void'(memq.pop_front());
      end
      if (exp_rv && mem_req_grant_in) begin
        b = todo_q.pop_front();
        req_log.push_back(b.addr);
        ctx_q.push_back(b);
        r.addr  = b.addr;
        r.ready = cyc + mem_lat;
        memq.push_back(r);
      end
      if (cmd_valid && cmd_ready) begin
        for (int i = 0; i < int'(cmd_lines); i++) begin
          b.addr = (cmd_addr & ~64'h3F) + 64'(i) * 64'd64;
          b.slot = cmd_slot;
          b.pad  = cmd_pad;
          b.last = (i == int'(cmd_lines) - 1);
          todo_q.push_back(b);
        end
      end
    end
  end

  task automatic send_cmd(input logic [63:0] a, input logic [31:0] n,
                          input logic [15:0] s, input logic [3:0] p,
                          output int out_at_accept);
    bit ok;
    ok = 1'b0;
    out_at_accept = -1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_lines = n; cmd_slot = s; cmd_pad = p;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        out_at_accept = int'(outstanding);
        break;
      end
    end
    if (!ok) bound_fail("cmd_accept");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_quiet(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && todo_q.size() == 0 && ctx_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("wait_quiet");
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int r0, b0, oa, total, n, lasts;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_orphan, 1'b0);
    chk("rst_req_valid", mem_req_out.valid, 1'b0);
    chk("rst_pkt_valid", pcie_packet_out.valid, 1'b0);

    // Single job; low address bits are ignored.
    r0 = req_log.size(); b0 = beat_log.size();
    send_cmd(64'h102A, 32'd4, 16'd7, 4'd3, oa);
    wait_quiet(200);
    chk("t1_req_count", req_log.size() - r0, 4);
    chk("t1_addr0", req_log[r0 + 0], 64'h1000);
    chk("t1_addr1", req_log[r0 + 1], 64'h1040);
    chk("t1_addr2", req_log[r0 + 2], 64'h1080);
    chk("t1_addr3", req_log[r0 + 3], 64'h10C0);
    chk("t1_beats", beat_log.size() - b0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_slot", beat_log[b0 + i].slot, 16'd7);
      chk("t1_last", beat_log[b0 + i].last, i == 3);
    end
    chk("t1_busy", busy, 1'b0);

    // Zero-line job.
    r0 = req_log.size(); b0 = beat_log.size();
    send_cmd(64'h8000, 32'd0, 16'd5, 4'd0, oa);
    repeat (5) @(negedge clk);
    chk("t2_no_req", req_log.size() - r0, 0);
    chk("t2_no_beat", beat_log.size() - b0, 0);
    chk("t2_idle", cmd_ready, 1'b1);

    // Credit cap with a stalled memory.
    @(negedge clk) mem_hold = 1'b1;
    r0 = req_log.size(); b0 = beat_log.size();
    send_cmd(64'h2000, 32'd10, 16'd4, 4'd1, oa);
    repeat (20) @(negedge clk);
    chk("t3_capped_grants", req_log.size() - r0, MAXO);
    chk("t3_outstanding", outstanding, MAXO);
    chk("t3_req_valid", mem_req_out.valid, 1'b0);
    mem_hold = 1'b0;
    wait_quiet(300);
    chk("t3_grants", req_log.size() - r0, 10);
    chk("t3_beats", beat_log.size() - b0, 10);
    lasts = 0;
    for (int i = 0; i < 10; i++) if (beat_log[b0 + i].last) lasts++;
    chk("t3_last_count", lasts, 1);
    chk("t3_final_last", beat_log[b0 + 9].last, 1'b1);

    // PCIe back-pressure mid-job.
    b0 = beat_log.size();
    send_cmd(64'h3000, 32'd8, 16'd9, 4'd5, oa);
    repeat (5) @(negedge clk);
    pcie_hold = 1'b1;
    @(negedge clk);
    n = beat_log.size();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_held_grant", mem_resp_grant_out, 1'b0);
    end
    chk("t4_held_no_beats", beat_log.size() - n, 0);
    chk("t4_held_outstanding", outstanding, MAXO);
    pcie_hold = 1'b0;
    wait_quiet(300);
    chk("t4_beats", beat_log.size() - b0, 8);
    for (int i = 0; i < 8; i++)
      chk("t4_order", beat_log[b0 + i].addr, 64'h3000 + 64'(i) * 64'd64);

    // Back-to-back jobs: B accepted while A still in flight.
    b0 = beat_log.size();
    send_cmd(64'h4000, 32'd3, 16'd1, 4'd0, oa);
    send_cmd(64'h5000, 32'd2, 16'd2, 4'd0, oa);
    chk("t5_b_overlaps_a", oa > 0, 1'b1);
    wait_quiet(200);
    chk("t5_beats", beat_log.size() - b0, 5);
    chk("t5_slot0", beat_log[b0 + 0].slot, 16'd1);
    chk("t5_slot2", beat_log[b0 + 2].slot, 16'd1);
    chk("t5_slot3", beat_log[b0 + 3].slot, 16'd2);
    chk("t5_last", {beat_log[b0 + 0].last, beat_log[b0 + 1].last, beat_log[b0 + 2].last,
                    beat_log[b0 + 3].last, beat_log[b0 + 4].last}, 5'b00101);

    // Orphan response.
    b0 = beat_log.size();
    @(negedge clk) inject_orphan = 1'b1;
    @(negedge clk) inject_orphan = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_err_set", err_orphan, 1'b1);
    chk("t6_no_beat", beat_log.size() - b0, 0);
    repeat (5) @(negedge clk);
    chk("t6_err_sticky", err_orphan, 1'b1);

    // Reset mid-job.
    @(negedge clk) mem_hold = 1'b1;
    send_cmd(64'h6000, 32'd10, 16'd3, 4'd2, oa);
    repeat (5) @(negedge clk);
    @(posedge clk) #1 rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    @(negedge clk);
    chk("t7_outstanding", outstanding, 0);
    chk("t7_busy", busy, 1'b0);
    chk("t7_err", err_orphan, 1'b0);
    chk("t7_cmd_ready", cmd_ready, 1'b1);
    mem_hold = 1'b0;
    b0 = beat_log.size();
    send_cmd(64'h7000, 32'd2, 16'd6, 4'd1, oa);
    wait_quiet(200);
    chk("t7_after_beats", beat_log.size() - b0, 2);

    // Randomized jobs, including an address wrap.
    rand_mode = 1'b1;
    b0 = beat_log.size();
    total = 0;
    for (int j = 0; j < 12; j++) begin
      logic [63:0] a;
      mem_lat = $urandom_range(1, 5);
      a = {$urandom(), $urandom()};
      if (j == 5) a = 64'hFFFF_FFFF_FFFF_FF80;
      n = $urandom_range(0, 9);
      total += n;
      send_cmd(a, 32'(n), 16'($urandom()), 4'($urandom()), oa);
    end
    wait_quiet(3000);
    chk("t8_total_beats", beat_log.size() - b0, total);
    rand_mode = 1'b0;

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
